// File: rtl/clint_pkg.sv
// Shared types and default register map for the core-local interruptor.
package clint_pkg;

  localparam int unsigned MSIP_BASE_DEF     = 32'h0000_0000;
  localparam int unsigned MTIMECMP_BASE_DEF = 32'h0000_4000;
  localparam int unsigned MTIME_ADDR_DEF    = 32'h0000_BFF8;
  localparam int unsigned REQ_ADDR_W        = 32;

  typedef struct packed {
    logic                  wr;
    logic [REQ_ADDR_W-1:0] addr;
    logic [63:0]           wdata;
    logic [7:0]            be;
  } req_t;

  typedef struct packed {
    logic [63:0] rdata;
    logic        error;
  } rsp_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RESP = 1'b1
  } state_e;

  function automatic logic [63:0] merge_bytes(input logic [63:0] old_val,
                                              input logic [63:0] wdata,
                                              input logic [7:0]  be);
    logic [63:0] res;
    for (int i = 0; i < 8; i++) begin
      res[8*i +: 8] = be[i] ? wdata[8*i +: 8] : old_val[8*i +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/clint_mtime_counter.sv
// Prescaled 64-bit mtime counter; a register-port write overrides a coincident tick.
module clint_mtime_counter
  import clint_pkg::*;
#(
  parameter int unsigned PRESCALE = 1
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_wr_en,
  input  logic [63:0] i_wdata,
  input  logic [7:0]  i_be,
  output logic [63:0] o_mtime
);

  localparam int unsigned CNT_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  logic [CNT_W-1:0] pre_cnt;
  logic             tick;
  logic [63:0]      mtime;

  assign tick    = (pre_cnt == CNT_W'(PRESCALE - 1));
  assign o_mtime = mtime;

  // The prescaler free-runs regardless of writes so the tick cadence never slips.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      pre_cnt <= '0;
      mtime   <= '0;
    end else begin
      pre_cnt <= tick ? '0 : pre_cnt + CNT_W'(1);
      if (i_wr_en) begin
        mtime <= merge_bytes(mtime, i_wdata, i_be);
      end else if (tick) begin
        mtime <= mtime + 64'd1;
      end
    end
  end

endmodule

// File: rtl/clint_multi_hart.sv
// Core-local interruptor: shared mtime, per-hart msip/mtimecmp, one request/response register port.
module clint_multi_hart
  import clint_pkg::*;
#(
  parameter int unsigned HART_NUM      = 4,
  parameter int unsigned ADDR_W        = 16,
  parameter int unsigned PRESCALE      = 1,
  parameter int unsigned MSIP_BASE     = MSIP_BASE_DEF,
  parameter int unsigned MTIMECMP_BASE = MTIMECMP_BASE_DEF,
  parameter int unsigned MTIME_ADDR    = MTIME_ADDR_DEF
) (
  input  logic                i_clk,
  input  logic                i_reset,
  input  logic                i_req_valid,
  output logic                o_req_ready,
  input  logic                i_req_wr,
  input  logic [ADDR_W-1:0]   i_req_addr,
  input  logic [63:0]         i_req_wdata,
  input  logic [7:0]          i_req_be,
  output logic                o_rsp_valid,
  input  logic                i_rsp_ready,
  output logic [63:0]         o_rsp_rdata,
  output logic                o_rsp_error,
  output logic [HART_NUM-1:0] o_ipi_valid,
  output logic [HART_NUM-1:0] o_time_irq_valid,
  output logic [63:0]         o_mtime
);

  localparam int unsigned IDX_W = (HART_NUM > 1) ? $clog2(HART_NUM) : 1;

  req_t                req;
  rsp_t                rsp_d;
  rsp_t                rsp_q;
  state_e              state;
  logic                accept;
  logic [31:0]         msip_off;
  logic [31:0]         cmp_off;
  logic                msip_hit;
  logic                cmp_hit;
  logic                mtime_hit;
  logic [IDX_W-1:0]    msip_idx;
  logic [IDX_W-1:0]    cmp_idx;
  logic                msip_lane_be;
  logic                msip_bit;
  logic [HART_NUM-1:0] msip;
  logic [63:0]         mtimecmp [HART_NUM];
  logic [63:0]         mtime;

  assign req = '{wr: i_req_wr, addr: REQ_ADDR_W'(i_req_addr), wdata: i_req_wdata, be: i_req_be};
  assign accept = (state == ST_IDLE) && i_req_valid;

  // Region decode is prioritised so exactly one target is selected even with overlapping maps.
  assign msip_off  = req.addr - MSIP_BASE;
  assign cmp_off   = req.addr - MTIMECMP_BASE;
  assign mtime_hit = ((req.addr >> 3) == (MTIME_ADDR >> 3));
  assign cmp_hit   = !mtime_hit && (req.addr >= MTIMECMP_BASE) && ((cmp_off >> 3) < HART_NUM);
  assign msip_hit  = !mtime_hit && !cmp_hit && (req.addr >= MSIP_BASE) && ((msip_off >> 2) < HART_NUM);
  assign msip_idx  = msip_off[IDX_W+1:2];
  assign cmp_idx   = cmp_off[IDX_W+2:3];

  assign msip_lane_be = req.addr[2] ? req.be[4] : req.be[0];
  assign msip_bit     = req.addr[2] ? req.wdata[32] : req.wdata[0];

  always_comb begin
    rsp_d = '{rdata: 64'd0, error: 1'b0};
    if (mtime_hit) begin
      if (!req.wr) rsp_d.rdata = mtime;
    end else if (cmp_hit) begin
      if (!req.wr) rsp_d.rdata = mtimecmp[cmp_idx];
    end else if (msip_hit) begin
      if (!req.wr) rsp_d.rdata = req.addr[2] ? {31'd0, msip[msip_idx], 32'd0}
                                             : {63'd0, msip[msip_idx]};
    end else begin
      rsp_d.error = 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state       <= ST_IDLE;
      o_req_ready <= 1'b1;
      o_rsp_valid <= 1'b0;
      rsp_q       <= '0;
    end else begin
      case (state)
        ST_IDLE: if (i_req_valid) begin
          state       <= ST_RESP;
          o_req_ready <= 1'b0;
          o_rsp_valid <= 1'b1;
          rsp_q       <= rsp_d;
        end
        ST_RESP: if (i_rsp_ready) begin
          state       <= ST_IDLE;
          o_req_ready <= 1'b1;
          o_rsp_valid <= 1'b0;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign o_rsp_rdata = rsp_q.rdata;
  assign o_rsp_error = rsp_q.error;

  clint_mtime_counter #(
    .PRESCALE (PRESCALE)
  ) u_mtime (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_wr_en (accept && req.wr && mtime_hit),
    .i_wdata (req.wdata),
    .i_be    (req.be),
    .o_mtime (mtime)
  );

  assign o_mtime = mtime;

  for (genvar h = 0; h < HART_NUM; h++) begin : g_hart
    logic        msip_q;
    logic [63:0] cmp_q;
    logic        ipi_q;
    logic        tirq_q;

    // Interrupt levels are registered from the current register values, one cycle behind them.
    always_ff @(posedge i_clk) begin
      if (i_reset) begin
        msip_q <= 1'b0;
        cmp_q  <= '1;
        ipi_q  <= 1'b0;
        tirq_q <= 1'b0;
      end else begin
        if (accept && req.wr && msip_hit && msip_lane_be && (msip_idx == IDX_W'(h))) begin
          msip_q <= msip_bit;
        end
        if (accept && req.wr && cmp_hit && (cmp_idx == IDX_W'(h))) begin
          cmp_q <= merge_bytes(cmp_q, req.wdata, req.be);
        end
        ipi_q  <= msip_q;
        tirq_q <= (mtime >= cmp_q);
      end
    end

    assign msip[h]             = msip_q;
    assign mtimecmp[h]         = cmp_q;
    assign o_ipi_valid[h]      = ipi_q;
    assign o_time_irq_valid[h] = tirq_q;
  end

endmodule

// File: tb/tb_clint_multi_hart.sv
// Bench for clint_multi_hart: two instances (PRESCALE 1 and 3) on one shared register port.
module tb_clint_multi_hart;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_wr = 1'b0;
  logic        rsp_ready = 1'b0;
  logic [15:0] req_addr = '0;
  logic [63:0] req_wdata = '0;
  logic [7:0]  req_be = '0;
  logic        req_ready1, rsp_valid1, rsp_err1, req_ready3, rsp_valid3, rsp_err3;
  logic [63:0] rdata1, rdata3, mtime1, mtime3;
  logic [3:0]  ipi1, tirq1, ipi3, tirq3;

  int errors = 0;
  int checks = 0;
  longint unsigned cyc = 0;

  // Reference model: mtime = anchor value + ticks since anchor, ticks = floor(edges / P).
  logic [63:0]     mv1 = '0, mv3 = '0;
  longint unsigned mw1 = 0, mw3 = 0;
  logic [63:0]     cmp_m [4];
  logic [3:0]      msip_m = '0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= rst ? 0 : cyc + 1;

  clint_multi_hart #(.HART_NUM(4), .ADDR_W(16), .PRESCALE(1)) dut1 (
    .i_clk(clk), .i_reset(rst), .i_req_valid(req_valid), .o_req_ready(req_ready1),
    .i_req_wr(req_wr), .i_req_addr(req_addr), .i_req_wdata(req_wdata), .i_req_be(req_be),
    .o_rsp_valid(rsp_valid1), .i_rsp_ready(rsp_ready), .o_rsp_rdata(rdata1),
    .o_rsp_error(rsp_err1), .o_ipi_valid(ipi1), .o_time_irq_valid(tirq1), .o_mtime(mtime1));

  clint_multi_hart #(.HART_NUM(4), .ADDR_W(16), .PRESCALE(3)) dut3 (
    .i_clk(clk), .i_reset(rst), .i_req_valid(req_valid), .o_req_ready(req_ready3),
    .i_req_wr(req_wr), .i_req_addr(req_addr), .i_req_wdata(req_wdata), .i_req_be(req_be),
    .o_rsp_valid(rsp_valid3), .i_rsp_ready(rsp_ready), .o_rsp_rdata(rdata3),
    .o_rsp_error(rsp_err3), .o_ipi_valid(ipi3), .o_time_irq_valid(tirq3), .o_mtime(mtime3));

  function automatic logic [63:0] exp_mtime(longint unsigned p, logic [63:0] v,
                                            longint unsigned w, longint unsigned k);
    return v + 64'(k / p) - 64'(w / p);
  endfunction

  function automatic logic [63:0] mt1(longint unsigned k);
    return exp_mtime(1, mv1, mw1, k);
  endfunction

  function automatic logic [63:0] mt3(longint unsigned k);
    return exp_mtime(3, mv3, mw3, k);
  endfunction

  function automatic logic [3:0] exp_irq(logic [63:0] mt);
    logic [3:0] r;
    for (int h = 0; h < 4; h++) r[h] = (mt >= cmp_m[h]);
    return r;
  endfunction

  function automatic logic [63:0] merge(logic [63:0] o, logic [63:0] d, logic [7:0] be);
    logic [63:0] r;
    for (int i = 0; i < 8; i++) r[8*i +: 8] = be[i] ? d[8*i +: 8] : o[8*i +: 8];
    return r;
  endfunction

  // {error, rdata} a read of address a should return, given the current model state.
  function automatic logic [64:0] exp_read(logic [15:0] a, logic [63:0] mt);
    int unsigned ai = 32'(a);
    if (ai >= 32'hBFF8 && ai <= 32'hBFFF) return {1'b0, mt};
    if (ai >= 32'h4000 && ai < 32'h4020) return {1'b0, cmp_m[(ai - 32'h4000) / 8]};
    if (ai < 32'h10) return {1'b0, 64'(msip_m[ai / 4]) << ((ai / 4) % 2 == 1 ? 32 : 0)};
    return {1'b1, 64'd0};
  endfunction

  task automatic model_reset();
    mv1 = '0; mv3 = '0; mw1 = 0; mw3 = 0; msip_m = '0;
    for (int h = 0; h < 4; h++) cmp_m[h] = '1;
  endtask

  // One complete transaction; returns actual and model-expected {error, rdata} per instance.
  task automatic do_req(input logic wr, input logic [15:0] addr, input logic [63:0] wdata,
                        input logic [7:0] be, output logic [64:0] r1, output logic [64:0] r3,
                        output logic [64:0] e1, output logic [64:0] e3,
                        output logic [3:0] irq_resp, output longint unsigned acc);
    int n = 0;
    int unsigned ai = 32'(addr);
    while (!(req_ready1 && req_ready3) && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) begin
      errors++; checks++;
      $display("FAIL req_ready_timeout: ready1=%b ready3=%b required 1", req_ready1, req_ready3);
    end
    req_valid = 1'b1; req_wr = wr; req_addr = addr; req_wdata = wdata; req_be = be;
    @(negedge clk);
    req_valid = 1'b0;
    acc = cyc;
    r1 = {rsp_err1, rdata1};
    r3 = {rsp_err3, rdata3};
    irq_resp = tirq1;
    e1 = exp_read(addr, mt1(acc - 1));
    e3 = exp_read(addr, mt3(acc - 1));
    checks++;
    if (rsp_valid1 !== 1'b1 || rsp_valid3 !== 1'b1) begin
      errors++;
      $display("FAIL rsp_valid: got %b/%b required 1/1", rsp_valid1, rsp_valid3);
    end
    if (wr) begin
      e1[63:0] = '0;
      e3[63:0] = '0;
      if (ai >= 32'hBFF8 && ai <= 32'hBFFF) begin
        mv1 = merge(mt1(acc - 1), wdata, be); mw1 = acc;
        mv3 = merge(mt3(acc - 1), wdata, be); mw3 = acc;
      end else if (ai >= 32'h4000 && ai < 32'h4020) begin
        cmp_m[(ai - 32'h4000) / 8] = merge(cmp_m[(ai - 32'h4000) / 8], wdata, be);
      end else if (ai < 32'h10) begin
        if ((ai / 4) % 2 == 1 ? be[4] : be[0])
          msip_m[ai / 4] = (ai / 4) % 2 == 1 ? wdata[32] : wdata[0];
      end
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    model_reset();
    checks++;
    if (mtime1 !== 64'd0 || mtime3 !== 64'd0 || {ipi1, tirq1, ipi3, tirq3} !== 16'd0) begin
      errors++;
      $display("FAIL reset_state: mtime=%h/%h irqs=%h required 0", mtime1, mtime3, {ipi1, tirq1, ipi3, tirq3});
    end
    checks++;
    if ({req_ready1, req_ready3, rsp_valid1, rsp_valid3, rsp_err1, rsp_err3} !== 6'b110000 ||
        rdata1 !== 64'd0 || rdata3 !== 64'd0) begin
      errors++;
      $display("FAIL reset_port: rdy=%b%b vld=%b%b err=%b%b rdata=%h required ready=1 others 0",
               req_ready1, req_ready3, rsp_valid1, rsp_valid3, rsp_err1, rsp_err3, rdata1);
    end
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      checks++;
      if (mtime1 !== mt1(cyc) || mtime3 !== mt3(cyc)) begin
        errors++;
        $display("FAIL mtime_count: got %0d/%0d required %0d/%0d", mtime1, mtime3, mt1(cyc), mt3(cyc));
      end
      checks++;
      if ({tirq1, tirq3, ipi1, ipi3} !== 16'd0) begin
        errors++;
        $display("FAIL irq_after_reset: got %h required 0", {tirq1, tirq3, ipi1, ipi3});
      end
    end
  endtask

  task automatic test_timer_cmp();
    logic [64:0] r1, r3, e1, e3;
    logic [3:0] irq_resp;
    longint unsigned acc;
    logic [63:0] tgt;
    int n = 0;
    tgt = mt1(cyc) + 64'($urandom_range(12, 25));
    do_req(1'b1, 16'h4010, tgt, 8'hFF, r1, r3, e1, e3, irq_resp, acc);
    while (mtime1 !== tgt && n < 100) begin
      checks++;
      if (tirq1 !== exp_irq(mt1(cyc - 1)) || tirq3 !== exp_irq(mt3(cyc - 1))) begin
        errors++;
        $display("FAIL tirq_wait: got %b/%b required %b/%b", tirq1, tirq3,
                 exp_irq(mt1(cyc - 1)), exp_irq(mt3(cyc - 1)));
      end
      @(negedge clk);
      n++;
    end
    checks++;
    if (mtime1 !== tgt) begin
      errors++;
      $display("FAIL mtime_reach: got %0d required %0d", mtime1, tgt);
    end
    checks++;
    if (tirq1 !== 4'b0000) begin
      errors++;
      $display("FAIL tirq_latency: got %b required 0000 on the cycle mtime reaches cmp", tirq1);
    end
    @(negedge clk);
    checks++;
    if (tirq1 !== 4'b0100 || tirq3 !== 4'b0000) begin
      errors++;
      $display("FAIL tirq_set: got %b/%b required 0100/0000", tirq1, tirq3);
    end
    do_req(1'b1, 16'h4010, '1, 8'hFF, r1, r3, e1, e3, irq_resp, acc);
    checks++;
    if (irq_resp !== 4'b0100 || tirq1 !== 4'b0000) begin
      errors++;
      $display("FAIL tirq_clear: got %b then %b required 0100 then 0000", irq_resp, tirq1);
    end
  endtask

  task automatic test_msip();
    logic [64:0] r1, r3, e1, e3;
    logic [3:0] irq_resp;
    longint unsigned acc;
    logic [15:0] a;
    do_req(1'b1, 16'h0004, 64'h1 << 32, 8'hF0, r1, r3, e1, e3, irq_resp, acc);
    checks++;
    if (ipi1 !== 4'b0010 || ipi3 !== 4'b0010) begin
      errors++;
      $display("FAIL ipi_set: got %b/%b required 0010", ipi1, ipi3);
    end
    do_req(1'b0, 16'h0004, 64'd0, 8'h00, r1, r3, e1, e3, irq_resp, acc);
    checks++;
    if (r1 !== {1'b0, 64'h0000_0001_0000_0000} || r3 !== r1) begin
      errors++;
      $display("FAIL msip_read: got %h/%h required 0_0000000100000000", r1, r3);
    end
    do_req(1'b1, 16'h0004, 64'd0, 8'hF0, r1, r3, e1, e3, irq_resp, acc);
    checks++;
    if (ipi1 !== 4'b0000 || ipi3 !== 4'b0000) begin
      errors++;
      $display("FAIL ipi_clear: got %b/%b required 0000", ipi1, ipi3);
    end
    for (int i = 0; i < 10; i++) begin
      a = 16'($urandom_range(0, 3) * 4 + $urandom_range(0, 3));
      do_req(1'b1, a, {$urandom, $urandom}, 8'($urandom), r1, r3, e1, e3, irq_resp, acc);
      checks++;
      if (ipi1 !== msip_m || ipi3 !== msip_m || r1 !== e1) begin
        errors++;
        $display("FAIL msip_rand_wr addr=%h: ipi=%b/%b rsp=%h required ipi=%b rsp=%h",
                 a, ipi1, ipi3, r1, msip_m, e1);
      end
      do_req(1'b0, a, 64'd0, 8'h00, r1, r3, e1, e3, irq_resp, acc);
      checks++;
      if (r1 !== e1 || r3 !== e3) begin
        errors++;
        $display("FAIL msip_rand_rd addr=%h: got %h/%h required %h", a, r1, r3, e1);
      end
    end
  endtask

  task automatic test_mtime_wrap();
    logic [64:0] r1, r3, e1, e3;
    logic [3:0] irq_resp;
    longint unsigned acc;
    logic [15:0] a;
    do_req(1'b1, 16'h4000, 64'h8000_0000_0000_0000, 8'hFF, r1, r3, e1, e3, irq_resp, acc);
    do_req(1'b1, 16'h4008, 64'd2, 8'hFF, r1, r3, e1, e3, irq_resp, acc);
    do_req(1'b1, 16'hBFF8, 64'hFFFF_FFFF_FFFF_FFFE, 8'hFF, r1, r3, e1, e3, irq_resp, acc);
    for (int i = 0; i < 14; i++) begin
      checks++;
      if (mtime1 !== mt1(cyc) || mtime3 !== mt3(cyc)) begin
        errors++;
        $display("FAIL mtime_wrap: got %h/%h required %h/%h", mtime1, mtime3, mt1(cyc), mt3(cyc));
      end
      checks++;
      if (tirq1 !== exp_irq(mt1(cyc - 1)) || tirq3 !== exp_irq(mt3(cyc - 1))) begin
        errors++;
        $display("FAIL tirq_unsigned: got %b/%b required %b/%b", tirq1, tirq3,
                 exp_irq(mt1(cyc - 1)), exp_irq(mt3(cyc - 1)));
      end
      @(negedge clk);
    end
    checks++;
    if (mtime3 > 64'd10 || tirq3[0] !== 1'b0) begin
      errors++;
      $display("FAIL wrap_to_zero: mtime3=%h tirq3[0]=%b required small value and 0", mtime3, tirq3[0]);
    end
    for (int i = 0; i < 4; i++) begin
      a = 16'hBFF8 + 16'($urandom_range(0, 7));
      do_req(1'b1, a, {$urandom, $urandom}, 8'($urandom), r1, r3, e1, e3, irq_resp, acc);
      do_req(1'b0, a, 64'd0, 8'h00, r1, r3, e1, e3, irq_resp, acc);
      checks++;
      if (r1 !== e1 || r3 !== e3) begin
        errors++;
        $display("FAIL mtime_partial addr=%h: got %h/%h required %h/%h", a, r1, r3, e1, e3);
      end
    end
  endtask

  task automatic test_error();
    logic [64:0] r1, r3, e1, e3;
    logic [3:0] irq_resp, ipi_before;
    longint unsigned acc;
    req_valid = 1'b1; req_wr = 1'b0; req_addr = 16'h4020; req_be = 8'h00;
    @(negedge clk);
    req_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if ({rsp_valid1, rsp_valid3, req_ready1, req_ready3, rsp_err1, rsp_err3} !== 6'b110011 ||
          rdata1 !== 64'd0 || rdata3 !== 64'd0) begin
        errors++;
        $display("FAIL err_hold cycle %0d: vld=%b rdy=%b err=%b rdata=%h required 1/0/1/0",
                 i, rsp_valid1, req_ready1, rsp_err1, rdata1);
      end
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    checks++;
    if (rsp_valid1 !== 1'b0 || req_ready1 !== 1'b1) begin
      errors++;
      $display("FAIL err_release: vld=%b rdy=%b required 0/1", rsp_valid1, req_ready1);
    end
    ipi_before = ipi1;
    do_req(1'b1, 16'h0010, '1, 8'hFF, r1, r3, e1, e3, irq_resp, acc);
    checks++;
    if (r1 !== {1'b1, 64'd0} || ipi1 !== ipi_before) begin
      errors++;
      $display("FAIL err_write: rsp=%h ipi=%b required 1_0 and %b", r1, ipi1, ipi_before);
    end
    do_req(1'b0, 16'hBFFC, 64'd0, 8'h00, r1, r3, e1, e3, irq_resp, acc);
    checks++;
    if (r1 !== e1 || r3 !== e3) begin
      errors++;
      $display("FAIL mtime_alias_read: got %h/%h required %h/%h", r1, r3, e1, e3);
    end
  endtask

  task automatic test_back_to_back();
    req_valid = 1'b1; req_wr = 1'b0; req_addr = 16'h4018; rsp_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      checks++;
      if (rsp_valid1 !== ((i % 2) == 0) || req_ready1 !== ((i % 2) == 1) ||
          ((i % 2) == 0 && rdata1 !== cmp_m[3])) begin
        errors++;
        $display("FAIL back_to_back cycle %0d: vld=%b rdy=%b rdata=%h required vld=%b rdata=%h",
                 i, rsp_valid1, req_ready1, rdata1, (i % 2) == 0, cmp_m[3]);
      end
    end
    req_valid = 1'b0; rsp_ready = 1'b0;
  endtask

  task automatic test_reset_in_resp();
    req_valid = 1'b1; req_wr = 1'b1; req_addr = 16'hBFF8;
    req_wdata = {$urandom, $urandom} | 64'h1; req_be = 8'h0F;
    @(negedge clk);
    req_valid = 1'b0;
    checks++;
    if (rsp_valid1 !== 1'b1) begin
      errors++;
      $display("FAIL resp_pending: got %b required 1", rsp_valid1);
    end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({rsp_valid1, rsp_valid3, req_ready1, req_ready3} !== 4'b0011 ||
        mtime1 !== 64'd0 || mtime3 !== 64'd0) begin
      errors++;
      $display("FAIL reset_in_resp: vld=%b%b rdy=%b%b mtime=%h/%h required 00 11 0",
               rsp_valid1, rsp_valid3, req_ready1, req_ready3, mtime1, mtime3);
    end
    rst = 1'b0;
    model_reset();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if (mtime1 !== mt1(cyc) || mtime3 !== mt3(cyc) || {tirq1, ipi1} !== 8'd0) begin
        errors++;
        $display("FAIL post_reset: mtime=%0d/%0d irq=%h required %0d/%0d and 0",
                 mtime1, mtime3, {tirq1, ipi1}, mt1(cyc), mt3(cyc));
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_timer_cmp();
    test_msip();
    test_mtime_wrap();
    test_error();
    test_back_to_back();
    test_reset_in_resp();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
